// File: rtl/cuckoo_pkg.sv
// Shared definitions for the two-table cuckoo hash store (lookup and insert paths).
package cuckoo_pkg;

  localparam int KEY_W       = 32;
  localparam int IDX_W       = 5;
  localparam int TABLE_DEPTH = 1 << IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CMP,
    ST_DEL,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic             hit;
    logic             tbl;
    logic [IDX_W-1:0] index;
    logic             dup;
  } resp_t;

endpackage

// File: rtl/cuckoo_lookup_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc && (value_q != {CNT_W{1'b1}}))
      value_d = value_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/cuckoo_lookup.sv
// Read-side engine of the two-table cuckoo store: parallel probe, hit/dup report, stats.
// Optional delete-on-hit is built only when CUCKOO_DELETE_EN is defined.
module cuckoo_lookup #(
  parameter int KEY_W = cuckoo_pkg::KEY_W,
  parameter int IDX_W = cuckoo_pkg::IDX_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [KEY_W-1:0] req_key,
  input  logic [IDX_W-1:0] req_index1,
  input  logic [IDX_W-1:0] req_index2,
  input  logic             req_del,
  output logic             t1_rd_en,
  output logic             t2_rd_en,
  output logic [IDX_W-1:0] t1_rd_addr,
  output logic [IDX_W-1:0] t2_rd_addr,
  input  logic [KEY_W-1:0] t1_rd_data,
  input  logic [KEY_W-1:0] t2_rd_data,
  input  logic             t1_rd_filled,
  input  logic             t2_rd_filled,
  output logic             t1_clr_en,
  output logic             t2_clr_en,
  output logic [IDX_W-1:0] t1_clr_addr,
  output logic [IDX_W-1:0] t2_clr_addr,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_hit,
  output logic             resp_table,
  output logic [IDX_W-1:0] resp_index,
  output logic             resp_dup,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  import cuckoo_pkg::*;

  state_t           state_q, state_d;
  logic [KEY_W-1:0] key_q;
  logic [IDX_W-1:0] idx1_q, idx2_q;
  resp_t            resp_q, resp_d;
  logic             h1, h2, any_hit, accept;
  logic             hit_inc, miss_inc;

  assign accept  = req_valid && (state_q == ST_IDLE);
  assign h1      = t1_rd_filled && (t1_rd_data == key_q);
  assign h2      = t2_rd_filled && (t2_rd_data == key_q);
  assign any_hit = h1 || h2;

`ifdef CUCKOO_DELETE_EN
  logic del_q;
  always_ff @(posedge clk) begin
    if (accept) del_q <= req_del;
  end
`else
  logic unused_req_del;
  assign unused_req_del = req_del;
`endif

  always_ff @(posedge clk) begin
    if (accept) begin
      key_q  <= req_key;
      idx1_q <= req_index1;
      idx2_q <= req_index2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_RD;
      ST_RD:   state_d = ST_CMP;
`ifdef CUCKOO_DELETE_EN
      ST_CMP:  state_d = (any_hit && del_q) ? ST_DEL : ST_RESP;
      ST_DEL:  state_d = ST_RESP;
`else
      ST_CMP:  state_d = ST_RESP;
`endif
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Table 1 wins a double hit; the duplicate is flagged rather than resolved.
  always_comb begin
    resp_d       = '0;
    resp_d.hit   = any_hit;
    resp_d.tbl   = !h1 && h2;
    resp_d.dup   = h1 && h2;
    if (h1)      resp_d.index = idx1_q;
    else if (h2) resp_d.index = idx2_q;
  end

  always_ff @(posedge clk) begin
    if (rst)                     resp_q <= '0;
    else if (state_q == ST_CMP)  resp_q <= resp_d;
  end

  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    t1_rd_en    = (state_q == ST_RD);
    t2_rd_en    = (state_q == ST_RD);
    t1_rd_addr  = t1_rd_en ? idx1_q : '0;
    t2_rd_addr  = t2_rd_en ? idx2_q : '0;
    resp_valid  = (state_q == ST_RESP);
    t1_clr_en   = 1'b0;
    t2_clr_en   = 1'b0;
    t1_clr_addr = '0;
    t2_clr_addr = '0;
`ifdef CUCKOO_DELETE_EN
    // Masked by rst so a reset landing in DEL never destroys an entry.
    if ((state_q == ST_DEL) && !rst) begin
      t1_clr_en   = !resp_q.tbl;
      t2_clr_en   = resp_q.tbl;
      t1_clr_addr = resp_q.tbl ? '0 : resp_q.index;
      t2_clr_addr = resp_q.tbl ? resp_q.index : '0;
    end
`endif
  end

  assign resp_hit   = resp_q.hit;
  assign resp_table = resp_q.tbl;
  assign resp_index = resp_q.index;
  assign resp_dup   = resp_q.dup;

  assign hit_inc  = (state_q == ST_CMP) && any_hit;
  assign miss_inc = (state_q == ST_CMP) && !any_hit;

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .value (hit_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .value (miss_cnt)
  );

endmodule

// File: tb/tb_cuckoo_lookup.sv
// Bench for cuckoo_lookup: behavioural tables, expected-response queue, per-scenario tasks.
`timescale 1ns/1ps
module tb_cuckoo_lookup;
  import cuckoo_pkg::*;

  localparam int CW = 8;
`ifdef CUCKOO_DELETE_EN
  localparam bit DEL_EN = 1'b1;
`else
  localparam bit DEL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_del;
  logic [31:0]   req_key;
  logic [4:0]    req_index1, req_index2;
  logic          t1_rd_en, t2_rd_en;
  logic [4:0]    t1_rd_addr, t2_rd_addr;
  logic [31:0]   t1_rd_data, t2_rd_data;
  logic          t1_rd_filled, t2_rd_filled;
  logic          t1_clr_en, t2_clr_en;
  logic [4:0]    t1_clr_addr, t2_clr_addr;
  logic          resp_valid, resp_ready, resp_hit, resp_table, resp_dup;
  logic [4:0]    resp_index;
  logic [CW-1:0] hit_cnt, miss_cnt;

  logic [31:0] m1 [32];
  logic [31:0] m2 [32];
  logic        f1 [32];
  logic        f2 [32];

  resp_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    exp_hit = 0;
  int    exp_miss = 0;

  always #5 clk = ~clk;

  cuckoo_lookup #(.KEY_W(32), .IDX_W(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_index1(req_index1), .req_index2(req_index2), .req_del(req_del),
    .t1_rd_en(t1_rd_en), .t2_rd_en(t2_rd_en),
    .t1_rd_addr(t1_rd_addr), .t2_rd_addr(t2_rd_addr),
    .t1_rd_data(t1_rd_data), .t2_rd_data(t2_rd_data),
    .t1_rd_filled(t1_rd_filled), .t2_rd_filled(t2_rd_filled),
    .t1_clr_en(t1_clr_en), .t2_clr_en(t2_clr_en),
    .t1_clr_addr(t1_clr_addr), .t2_clr_addr(t2_clr_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_table(resp_table), .resp_index(resp_index),
    .resp_dup(resp_dup), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Synchronous-read table storage
  always @(posedge clk) begin
    if (t1_rd_en) begin
      t1_rd_data   <= m1[t1_rd_addr];
      t1_rd_filled <= f1[t1_rd_addr];
    end
    if (t2_rd_en) begin
      t2_rd_data   <= m2[t2_rd_addr];
      t2_rd_filled <= f2[t2_rd_addr];
    end
  end

  function automatic int sat_inc(input int v);
    return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
  endfunction

  task automatic do_lookup(input logic [31:0] key, input logic [4:0] i1, input logic [4:0] i2,
                           input logic del, input int hold, input string tag);
    resp_t      e, p;
    logic       h1, h2, ec1, ec2;
    int         exp_lat, lat, n1, n2, c1, c2, guard;
    logic [4:0] a1, a2;
    bit         got;
    h1      = f1[i1] && (m1[i1] == key);
    h2      = f2[i2] && (m2[i2] == key);
    e.hit   = h1 || h2;
    e.tbl   = !h1 && h2;
    e.index = h1 ? i1 : (h2 ? i2 : 5'd0);
    e.dup   = h1 && h2;
    ec1     = DEL_EN && del && h1;
    ec2     = DEL_EN && del && !h1 && h2;
    exp_lat = (ec1 || ec2) ? 4 : 3;
    if (e.hit) exp_hit = sat_inc(exp_hit);
    else       exp_miss = sat_inc(exp_miss);

    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s.ready got=%b want=1", tag, req_ready);
    end
    req_valid = 1'b1; req_key = key; req_index1 = i1; req_index2 = i2; req_del = del;
    resp_ready = (hold == 0);
    @(posedge clk);
    exp_q.push_back(e);
    #1 req_valid = 1'b0;

    lat = 0; got = 0; n1 = 0; n2 = 0; c1 = 0; c2 = 0; a1 = '0; a2 = '0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        total++;
        if ({t1_rd_en, t2_rd_en, t1_rd_addr, t2_rd_addr} !== {2'b11, i1, i2}) begin
          bad++;
          $display("FAIL %s.rd got=%b%b/%0d/%0d want=11/%0d/%0d", tag, t1_rd_en, t2_rd_en,
                   t1_rd_addr, t2_rd_addr, i1, i2);
        end
      end
      if (t1_clr_en) begin n1++; a1 = t1_clr_addr; c1 = lat; end
      if (t2_clr_en) begin n2++; a2 = t2_clr_addr; c2 = lat; end
      if (resp_valid) got = 1;
    end
    total++;
    if (!got || lat != exp_lat) begin
      bad++;
      $display("FAIL %s.latency got=%0d(valid=%0d) want=%0d", tag, lat, got, exp_lat);
    end

    for (int k = 0; k < hold; k++) begin
      total++;
      if ({resp_valid, req_ready, resp_hit, resp_dup, resp_table, resp_index} !==
          {1'b1, 1'b0, e.hit, e.dup, e.tbl, e.index}) begin
        bad++;
        $display("FAIL %s.hold%0d got=%b%b%b%b%b/%0d want=10%b%b%b/%0d", tag, k, resp_valid,
                 req_ready, resp_hit, resp_dup, resp_table, resp_index, e.hit, e.dup, e.tbl, e.index);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;

    p = '0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s.queue got=empty want=entry", tag);
    end else begin
      p = exp_q.pop_front();
      if (resp_hit !== p.hit || resp_dup !== p.dup) begin
        bad++;
        $display("FAIL %s.hitdup got=%b%b want=%b%b", tag, resp_hit, resp_dup, p.hit, p.dup);
      end
    end
    if (p.hit) begin
      total++;
      if (resp_table !== p.tbl || resp_index !== p.index) begin
        bad++;
        $display("FAIL %s.loc got=%b/%0d want=%b/%0d", tag, resp_table, resp_index, p.tbl, p.index);
      end
    end
    total++;
    if (hit_cnt !== CW'(exp_hit) || miss_cnt !== CW'(exp_miss)) begin
      bad++;
      $display("FAIL %s.cnt got=%0d/%0d want=%0d/%0d", tag, hit_cnt, miss_cnt, exp_hit, exp_miss);
    end
    total++;
    if (n1 != (ec1 ? 1 : 0) || (ec1 && (a1 !== i1 || c1 != 3))) begin
      bad++;
      $display("FAIL %s.clr1 got=n%0d a%0d c%0d want=n%0d a%0d c3", tag, n1, a1, c1, ec1, i1);
    end
    total++;
    if (n2 != (ec2 ? 1 : 0) || (ec2 && (a2 !== i2 || c2 != 3))) begin
      bad++;
      $display("FAIL %s.clr2 got=n%0d a%0d c%0d want=n%0d a%0d c3", tag, n2, a2, c2, ec2, i2);
    end
    if (ec1) f1[i1] = 1'b0;
    if (ec2) f2[i2] = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({req_ready, resp_valid, t1_rd_en, t2_rd_en, t1_clr_en, t2_clr_en} !== 6'b100000) begin
      bad++;
      $display("FAIL reset.ctl got=%b want=100000",
               {req_ready, resp_valid, t1_rd_en, t2_rd_en, t1_clr_en, t2_clr_en});
    end
    total++;
    if ({t1_rd_addr, t2_rd_addr, t1_clr_addr, t2_clr_addr, resp_hit, resp_table, resp_index,
         resp_dup, hit_cnt, miss_cnt} !== '0) begin
      bad++;
      $display("FAIL reset.data got=%0d/%0d/%0d/%0d/%b%b%0d%b/%0d/%0d want=all 0", t1_rd_addr,
               t2_rd_addr, t1_clr_addr, t2_clr_addr, resp_hit, resp_table, resp_index, resp_dup,
               hit_cnt, miss_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_hit_t1();
    m1[7] = 32'hDEADBEEF; f1[7] = 1'b1; f2[19] = 1'b0;
    do_lookup(32'hDEADBEEF, 5'd7, 5'd19, 1'b0, 0, "hit_t1");
  endtask

  task automatic test_hit_t2_edges();
    f1[0] = 1'b0; m2[31] = 32'h00000042; f2[31] = 1'b1;
    do_lookup(32'h00000042, 5'd0, 5'd31, 1'b0, 0, "hit_t2");
  endtask

  task automatic test_unfilled_miss();
    m1[3] = 32'h00000042; f1[3] = 1'b0; m2[10] = 32'h00000042; f2[10] = 1'b0;
    do_lookup(32'h00000042, 5'd3, 5'd10, 1'b1, 0, "unfilled");
  endtask

  task automatic test_dup_delete();
    m1[4] = 32'h1234ABCD; f1[4] = 1'b1; m2[9] = 32'h1234ABCD; f2[9] = 1'b1;
    do_lookup(32'h1234ABCD, 5'd4, 5'd9, 1'b1, 0, "dup_del");
    do_lookup(32'h1234ABCD, 5'd4, 5'd9, 1'b1, 0, "dup_del2");
    do_lookup(32'h1234ABCD, 5'd4, 5'd9, 1'b0, 0, "dup_del3");
  endtask

  task automatic test_stall();
    m2[17] = 32'h0BADF00D; f2[17] = 1'b1; f1[16] = 1'b0;
    do_lookup(32'h0BADF00D, 5'd16, 5'd17, 1'b0, 5, "stall");
  endtask

  task automatic test_back_to_back();
    resp_t e, p;
    int    accepts, resps, last;
    f1[1] = 1'b0; m2[2] = 32'hCAFE0001; f2[2] = 1'b1;
    e.hit = 1'b1; e.tbl = 1'b1; e.index = 5'd2; e.dup = 1'b0;
    accepts = 0; resps = 0; last = 0;
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_key = 32'hCAFE0001; req_index1 = 5'd1; req_index2 = 5'd2; req_del = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (resp_valid) begin
        resps++;
        total++;
        p = exp_q.size() != 0 ? exp_q.pop_front() : '0;
        if ({req_ready, resp_hit, resp_table, resp_index} !== {1'b0, p.hit, p.tbl, p.index}) begin
          bad++;
          $display("FAIL b2b.resp%0d got=%b%b%b/%0d want=0%b%b/%0d", resps, req_ready, resp_hit,
                   resp_table, resp_index, p.hit, p.tbl, p.index);
        end
      end
      if (req_valid && req_ready) begin
        if (accepts > 0) begin
          total++;
          if (c - last != 4) begin
            bad++;
            $display("FAIL b2b.gap got=%0d want=4", c - last);
          end
        end
        last = c;
        accepts++;
        exp_q.push_back(e);
        exp_hit = sat_inc(exp_hit);
        if (accepts == 3) begin
          @(posedge clk);
          #1 req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    total++;
    if (accepts != 3 || resps != 3 || hit_cnt !== CW'(exp_hit)) begin
      bad++;
      $display("FAIL b2b.count got=%0d/%0d/%0d want=3/3/%0d", accepts, resps, hit_cnt, exp_hit);
    end
  endtask

  task automatic test_reset_mid();
    int   target;
    logic seen;
    m1[12] = 32'h77665544; f1[12] = 1'b1; f2[13] = 1'b0;
    target = DEL_EN ? 3 : 2;
    @(negedge clk);
    req_valid = 1'b1; req_key = 32'h77665544; req_index1 = 5'd12; req_index2 = 5'd13; req_del = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (target) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({req_ready, resp_valid, t1_clr_en, t2_clr_en, hit_cnt, miss_cnt} !== {4'b1000, {(2*CW){1'b0}}}) begin
      bad++;
      $display("FAIL rstmid.after got=%b%b%b%b/%0d/%0d want=1000/0/0", req_ready, resp_valid,
               t1_clr_en, t2_clr_en, hit_cnt, miss_cnt);
    end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid || t1_clr_en || t2_clr_en) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rstmid.quiet got=%b want=0", seen);
    end
    exp_q.delete();
    exp_hit = 0;
    exp_miss = 0;
  endtask

  task automatic test_saturation();
    f1[20] = 1'b0; f2[21] = 1'b0;
    while (exp_miss < (1 << CW) - 1)
      do_lookup(32'h5A5A0000, 5'd20, 5'd21, 1'b0, 0, "sat_fill");
    do_lookup(32'h5A5A0000, 5'd20, 5'd21, 1'b0, 0, "sat_hold");
    total++;
    if (miss_cnt !== {CW{1'b1}}) begin
      bad++;
      $display("FAIL sat.final got=%0d want=%0d", miss_cnt, (1 << CW) - 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_key = '0; req_index1 = '0; req_index2 = '0;
    req_del = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      m1[i] = '0; m2[i] = '0; f1[i] = 1'b0; f2[i] = 1'b0;
    end
    test_reset();
    test_hit_t1();
    test_hit_t2_edges();
    test_unfilled_miss();
    test_dup_delete();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
